onehot_step_counter: RTL and testbench
======================================

// Module: onehot_step_counter
// PURPOSE
//   Upstream feeder for the one-hot-to-two-digit 7-segment decoder. Debounces
//   three push-buttons (up / down / load) and keeps a 4-bit value 0..15.
//   Presents that value as a registered 16-bit one-hot code, ready to wire
//   straight into the decoder's 16-bit input.
//   Auto-repeat applies while up or down is held. Load copies the 4 switches.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  consecutive stable cycles before a debounced level changes (>=2)
//   REPEAT_DELAY     25000000  cycles from press event to first auto-repeat; 0 = auto-repeat off
//   REPEAT_PERIOD    5000000   cycles between later auto-repeats (>=1)
// PORTS
//   clk       in   1   system clock, all state on rising edge
//   rst       in   1   asynchronous, active-high reset
//   btn_up    in   1   raw increment button, active-high, asynchronous to clk
//   btn_dn    in   1   raw decrement button, active-high, asynchronous to clk
//   btn_load  in   1   raw load button, active-high, asynchronous to clk
//   sw        in   4   load value, sampled on the load event cycle (quasi-static)
//   value     out  4   current count, binary
//   onehot    out  16  registered 1<<value; always exactly one bit set
//   step      out  1   one-cycle pulse on every clock edge where value is written
// BEHAVIOUR
//   Reset (async assert, sync use after release):
//     value=0, onehot=16'h0001, step=0; sync flops, debounced levels, all counters=0.
//   Synchronizer: each button passes a 2-flop synchronizer -> s2.
//   Debounce, per button:
//     - counter clears whenever s2==stable.
//     - counter increments each cycle s2!=stable.
//     - when the counter would reach DEBOUNCE_CYCLES: stable<=s2, counter<=0.
//     - a glitch shorter than DEBOUNCE_CYCLES never changes stable.
//   Press event: registered 1-cycle pulse, set on the same edge stable goes 0->1.
//     Release generates no event.
//   Auto-repeat (up/down only):
//     - hold counter clears on the press event, increments while stable==1,
//       clears on release.
//     - first repeat event at REPEAT_DELAY cycles after the press event,
//       then one every REPEAT_PERIOD cycles while held.
//   Update priority, evaluated per cycle:
//     1. load event: value<=sw.
//     2. up and down events in the same cycle: no change, step=0.
//     3. up: value<=value+1, wraps 15->0.
//     4. down: value<=value-1, wraps 0->15.
//   Latency:
//     - value, onehot and step update on the edge after the event pulse.
//     - button edge to onehot change = DEBOUNCE_CYCLES+3 rising edges.
//   onehot is computed from next-value in the same register stage as value,
//     so the two are never skewed.
//   step=1 for any write, including a load of an unchanged value.
//   rst mid-hold: all state clears immediately. A button still held after
//     release of rst produces a fresh press event after debounce, as a new press.
//   Counter widths: $clog2(param+1); no counter may overflow or wrap while held.
// TESTING (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
//   1. Reset release -> value=0, onehot=16'h0001, step=0.
//      Then hold btn_up 10 cycles -> onehot=16'h0002 on edge 7 after first
//      high sample, one step pulse.
//   2. Pulse btn_dn high for 3 cycles (glitch) at value=0 -> no change, step never 1.
//   3. From value=15, one debounced up press -> value=0, onehot=16'h0001 (wrap).
//      From value=0, one down press -> value=15, onehot=16'h8000.
//   4. Hold btn_up 60 cycles from value=3 -> press event, first repeat 20 cycles
//      later, then every 8 -> value=3+1+1+floor((60-7-20)/8)... checked exactly;
//      release stops repeats.
//   5. btn_up and btn_dn asserted on the same cycle for 10 cycles -> both events
//      coincide, value unchanged, step=0.
//   6. sw=4'hA, press btn_load while holding btn_up -> value=10, onehot=16'h0400.
//      Assert rst mid-hold -> value=0 at once; after rst release the held button
//      yields one new press -> value=1.

Source files
------------

// File: rtl/onehot_step_counter.sv
// -----------------------------------------------------------------------------
// onehot_step_counter_button
//   Conditions one raw push-button. The raw level is synchronised, debounced,
//   and turned into single-cycle registered events: one on each debounced
//   press and, when REPEAT_DELAY is non-zero, auto-repeat events while the
//   button stays held.
//
//   Ports
//     clk      in   system clock, all state on rising edge
//     rst      in   asynchronous active-high reset
//     btn_i    in   raw button level, active-high, asynchronous to clk
//     event_o  out  one-cycle pulse per press or auto-repeat
// -----------------------------------------------------------------------------
module onehot_step_counter_button #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic event_o
);

  localparam int  DW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int  HOLD_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int  HW        = $clog2(HOLD_MAX + 1);
  localparam bit  REPEAT_EN = (REPEAT_DELAY != 0);

  // HOLD_FIRST waits REPEAT_DELAY for the first repeat; HOLD_REPEAT then
  // fires every REPEAT_PERIOD. Both fall back to HOLD_IDLE on release.
  typedef enum logic [1:0] {
    HOLD_IDLE,
    HOLD_FIRST,
    HOLD_REPEAT
  } hold_e;

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rise, fall;
  hold_e         hold_q, hold_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          rep;
  logic          event_q, event_d;

  // Debounce: the counter measures how long s2 has disagreed with the
  // debounced level; any agreement restarts the measurement.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    if (s2_q != stable_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2_q;
        rise     = s2_q;
        fall     = ~s2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // Auto-repeat: the hold counter restarts after each repeat, so it never
  // exceeds the larger of the two intervals however long the button is held.
  // A release on this edge takes priority over a repeat due on the same edge.
  always_comb begin
    hold_d = hold_q;
    hcnt_d = hcnt_q;
    rep    = 1'b0;
    unique case (hold_q)
      HOLD_IDLE: begin
        hcnt_d = '0;
        if (rise && REPEAT_EN) hold_d = HOLD_FIRST;
      end
      HOLD_FIRST: begin
        if (fall) begin
          hold_d = HOLD_IDLE;
          hcnt_d = '0;
        end else if (hcnt_q == HW'(REPEAT_DELAY - 1)) begin
          rep    = 1'b1;
          hcnt_d = '0;
          hold_d = HOLD_REPEAT;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      HOLD_REPEAT: begin
        if (fall) begin
          hold_d = HOLD_IDLE;
          hcnt_d = '0;
        end else if (hcnt_q == HW'(REPEAT_PERIOD - 1)) begin
          rep    = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        hold_d = HOLD_IDLE;
        hcnt_d = '0;
      end
    endcase
  end

  assign event_d = rise | rep;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      hold_q   <= HOLD_IDLE;
      hcnt_q   <= '0;
      event_q  <= 1'b0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      hold_q   <= hold_d;
      hcnt_q   <= hcnt_d;
      event_q  <= event_d;
    end
  end

  assign event_o = event_q;

endmodule

// -----------------------------------------------------------------------------
// onehot_step_counter
//   Keeps a 4-bit value 0..15 driven by three debounced push-buttons
//   (up / down with auto-repeat, load from switches) and presents it both in
//   binary and as a registered 16-bit one-hot code for a downstream decoder.
//
//   Ports
//     clk       in   system clock, all state on rising edge
//     rst       in   asynchronous active-high reset
//     btn_up    in   raw increment button, active-high, asynchronous
//     btn_dn    in   raw decrement button, active-high, asynchronous
//     btn_load  in   raw load button, active-high, asynchronous
//     sw[3:0]   in   load value, sampled on the load event cycle
//     value     out  current count, binary
//     onehot    out  registered 1 << value, exactly one bit set
//     step      out  one-cycle pulse on every edge where value is written
// -----------------------------------------------------------------------------
module onehot_step_counter #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        btn_load,
  input  logic [3:0]  sw,
  output logic [3:0]  value,
  output logic [15:0] onehot,
  output logic        step
);

  logic        ev_up, ev_dn, ev_load;
  logic [3:0]  value_q, value_d;
  logic [15:0] onehot_q, onehot_d;
  logic        step_q, step_d;

  onehot_step_counter_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_btn_up (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_up),
    .event_o (ev_up)
  );

  onehot_step_counter_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_btn_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_dn),
    .event_o (ev_dn)
  );

  // Load never auto-repeats.
  onehot_step_counter_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (0),
    .REPEAT_PERIOD   (1)
  ) u_btn_load (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_load),
    .event_o (ev_load)
  );

  // Load wins; simultaneous up and down cancel; 4-bit arithmetic gives the
  // 15->0 and 0->15 wrap. onehot is decoded from value_d so both registers
  // load on the same edge and are never skewed.
  always_comb begin
    value_d = value_q;
    step_d  = 1'b0;
    if (ev_load) begin
      value_d = sw;
      step_d  = 1'b1;
    end else if (ev_up && ev_dn) begin
      value_d = value_q;
    end else if (ev_up) begin
      value_d = value_q + 4'd1;
      step_d  = 1'b1;
    end else if (ev_dn) begin
      value_d = value_q - 4'd1;
      step_d  = 1'b1;
    end
    onehot_d = 16'd1 << value_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q  <= 4'd0;
      onehot_q <= 16'h0001;
      step_q   <= 1'b0;
    end else begin
      value_q  <= value_d;
      onehot_q <= onehot_d;
      step_q   <= step_d;
    end
  end

  assign value  = value_q;
  assign onehot = onehot_q;
  assign step   = step_q;

endmodule

// File: tb/tb_onehot_step_counter.sv
// -----------------------------------------------------------------------------
// tb_onehot_step_counter
//   Bench for onehot_step_counter with short debounce / repeat parameters.
//   Directed vectors and hand sequences check fixed expected values; a
//   cycle-level reference model checks every cycle during the whole run,
//   including a randomised button phase.
// -----------------------------------------------------------------------------
module tb_onehot_step_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_dn = 1'b0;
  logic        btn_load = 1'b0;
  logic [3:0]  sw = 4'd0;
  logic [3:0]  value;
  logic [15:0] onehot;
  logic        step;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  onehot_step_counter #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .btn_load (btn_load),
    .sw       (sw),
    .value    (value),
    .onehot   (onehot),
    .step     (step)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Index 0 = up, 1 = down, 2 = load. Repeats are derived
  // from the number of cycles held since the press: one at RD, then every RP.
  // ---------------------------------------------------------------------------
  logic       m_s1[3], m_s2[3], m_stable[3], m_ev[3];
  int         m_run[3], m_held[3];
  logic [3:0] m_value;
  logic       m_step;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_stable[b] = 1'b0; m_ev[b] = 1'b0;
      m_run[b] = 0;   m_held[b] = 0;
    end
    m_value = 4'd0;
    m_step  = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] raw;
    raw = {btn_load, btn_dn, btn_up};
    // value update from events that became visible after the previous edge
    m_step = 1'b0;
    if (m_ev[2]) begin
      m_value = sw;
      m_step  = 1'b1;
    end else if (m_ev[0] && !m_ev[1]) begin
      m_value = 4'((int'(m_value) + 1) % 16);
      m_step  = 1'b1;
    end else if (m_ev[1] && !m_ev[0]) begin
      m_value = 4'((int'(m_value) + 15) % 16);
      m_step  = 1'b1;
    end
    for (int b = 0; b < 3; b++) begin
      logic rise, fall, ev;
      rise = 1'b0; fall = 1'b0; ev = 1'b0;
      if (m_s2[b] == m_stable[b]) m_run[b] = 0;
      else if (m_run[b] + 1 == DB) begin
        m_stable[b] = m_s2[b];
        m_run[b]    = 0;
        rise        = m_stable[b];
        fall        = !m_stable[b];
      end else m_run[b]++;
      if (rise) begin
        m_held[b] = 0;
        ev        = 1'b1;
      end else if (m_stable[b] && !fall) begin
        m_held[b]++;
        if (b < 2 && (m_held[b] == RD || (m_held[b] > RD && (m_held[b] - RD) % RP == 0)))
          ev = 1'b1;
      end else m_held[b] = 0;
      m_ev[b] = ev;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("model_value",  {28'd0, value}, {28'd0, m_value});
        check("model_onehot", {16'd0, onehot}, {16'd0, 16'd1 << m_value});
        check("model_step",   {31'd0, step},   {31'd0, m_step});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        up, dn, load;
    logic [3:0]  sw;
    int          hold;
    logic [3:0]  exp_value;
    logic [15:0] exp_onehot;
    int          exp_steps;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic up, input logic dn,
                              input logic load, input logic [3:0] swv, input int hold,
                              input logic [3:0] ev, input logic [15:0] eo, input int es);
    vec_t v;
    v.name = name; v.up = up; v.dn = dn; v.load = load; v.sw = swv; v.hold = hold;
    v.exp_value = ev; v.exp_onehot = eo; v.exp_steps = es;
    return v;
  endfunction

  task automatic cycles(input int n, inout int steps);
    repeat (n) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
  endtask

  task automatic apply(input vec_t v);
    int steps;
    steps = 0;
    sw = v.sw; btn_up = v.up; btn_dn = v.dn; btn_load = v.load;
    cycles(v.hold, steps);
    btn_up = 1'b0; btn_dn = 1'b0; btn_load = 1'b0;
    cycles(12, steps);
    check({v.name, "_value"},  {28'd0, value},  {28'd0, v.exp_value});
    check({v.name, "_onehot"}, {16'd0, onehot}, {16'd0, v.exp_onehot});
    check({v.name, "_steps"},  steps, v.exp_steps);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_value",  {28'd0, value},  32'd0);
    check("reset_onehot", {16'd0, onehot}, 32'h0001);
    check("reset_step",   {31'd0, step},   32'd0);
    mon_en = 1'b1;

    // First up press: onehot changes on the 7th edge after the first high sample.
    steps  = 0;
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
      if (k == 6) check("first_press_edge6_onehot", {16'd0, onehot}, 32'h0001);
      if (k == 7) begin
        check("first_press_edge7_onehot", {16'd0, onehot}, 32'h0002);
        check("first_press_edge7_step",   {31'd0, step},   32'd1);
      end
    end
    btn_up = 1'b0;
    cycles(12, steps);
    check("first_press_steps", steps, 1);
    check("first_press_value", {28'd0, value}, 32'd1);

    vecs.push_back(mk("dn_press",    0, 1, 0, 4'h0,  8, 4'd0,  16'h0001, 1));
    vecs.push_back(mk("dn_glitch",   0, 1, 0, 4'h0,  3, 4'd0,  16'h0001, 0));
    vecs.push_back(mk("dn_wrap",     0, 1, 0, 4'h0,  8, 4'd15, 16'h8000, 1));
    vecs.push_back(mk("up_wrap",     1, 0, 0, 4'h0,  8, 4'd0,  16'h0001, 1));
    vecs.push_back(mk("load_f",      0, 0, 1, 4'hF,  8, 4'd15, 16'h8000, 1));
    vecs.push_back(mk("up_wrap2",    1, 0, 0, 4'h0,  8, 4'd0,  16'h0001, 1));
    vecs.push_back(mk("load_3",      0, 0, 1, 4'h3,  8, 4'd3,  16'h0008, 1));
    vecs.push_back(mk("up_hold60",   1, 0, 0, 4'h0, 60, 4'd9,  16'h0200, 6));
    vecs.push_back(mk("up_dn_same",  1, 1, 0, 4'h0, 10, 4'd9,  16'h0200, 0));
    vecs.push_back(mk("load_same",   0, 0, 1, 4'h9,  8, 4'd9,  16'h0200, 1));
    vecs.push_back(mk("load_glitch", 0, 0, 1, 4'h0,  3, 4'd9,  16'h0200, 0));
    vecs.push_back(mk("dn_min_press",0, 1, 0, 4'h0,  4, 4'd8,  16'h0100, 1));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Load while up is held, then reset mid-hold.
    steps  = 0;
    sw     = 4'hA;
    btn_up = 1'b1;
    cycles(10, steps);
    check("hold_up_value", {28'd0, value}, 32'd9);
    btn_load = 1'b1;
    cycles(8, steps);
    check("load_during_hold_value",  {28'd0, value},  32'd10);
    check("load_during_hold_onehot", {16'd0, onehot}, 32'h0400);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_hold_value",  {28'd0, value},  32'd0);
    check("rst_mid_hold_onehot", {16'd0, onehot}, 32'h0001);
    check("rst_mid_hold_step",   {31'd0, step},   32'd0);
    btn_load = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    steps = 0;
    cycles(8, steps);
    check("held_after_rst_value",  {28'd0, value},  32'd1);
    check("held_after_rst_onehot", {16'd0, onehot}, 32'h0002);
    check("held_after_rst_steps",  steps, 1);
    btn_up = 1'b0;
    cycles(12, steps);
    check("released_after_rst_value", {28'd0, value}, 32'd1);

    // Randomised phase, checked by the model every cycle.
    for (int seg = 0; seg < 150; seg++) begin
      btn_up   = ($urandom_range(0, 9) < 3);
      btn_dn   = ($urandom_range(0, 9) < 3);
      btn_load = ($urandom_range(0, 9) < 2);
      sw       = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    btn_up = 1'b0; btn_dn = 1'b0; btn_load = 1'b0;
    repeat (30) @(negedge clk);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
